// File: rtl/dummy_accelerator_pipe.sv
// Pipelined dummy accelerator: fixed-latency ALU pipeline feeding an in-order
// response FIFO, with credit-based flow control and a synchronous flush.

package riscv;
    localparam int unsigned XLEN = 64;
endpackage

package acc_pkg;
    localparam int unsigned TRANS_ID_BITS = 4;

    typedef struct packed {
        logic                     req_valid;
        logic                     resp_ready;
        logic [31:0]              insn;
        logic [riscv::XLEN-1:0]   rs1;
        logic [riscv::XLEN-1:0]   rs2;
        logic [2:0]               frm;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic                     store_pending;
        logic                     acc_cons_en;
        logic                     inval_ready;
    } accelerator_req_t;

    typedef struct packed {
        logic                     req_ready;
        logic                     resp_valid;
        logic [riscv::XLEN-1:0]   result;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic                     error;
        logic                     fflags_valid;
        logic [4:0]               fflags;
        logic                     load_complete;
        logic                     store_complete;
        logic                     inval_valid;
        logic [63:0]              inval_addr;
    } accelerator_resp_t;
endpackage

module dummy_accelerator_pipe
    import acc_pkg::*;
#(
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  accelerator_req_t  acc_req_i,
    output accelerator_resp_t acc_resp_o,
    output logic              busy_o
);
    localparam int unsigned XLEN  = riscv::XLEN;
    localparam int unsigned SHW   = $clog2(XLEN);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    typedef struct packed {
        logic [XLEN-1:0]          result;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic                     error;
    } entry_t;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    logic             r_req_ready;
    logic             r_resp_valid;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_fifo_cnt;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;

    logic             w_req_fire;
    logic             w_resp_fire;
    logic             w_fifo_write;
    logic             w_fifo_push;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_fifo_cnt_next;
    logic [2:0]       w_op;
    entry_t           w_entry;
    entry_t           w_fifo_wdata;
    entry_t           w_head;
    logic             w_unused;

    // req_ready is a registered credit, so a flush must still gate the fire.
    assign w_req_fire  = acc_req_i.req_valid && r_req_ready && !flush_i;
    assign w_resp_fire = r_resp_valid && acc_req_i.resp_ready;
    assign w_op        = acc_req_i.insn[14:12];

    assign w_unused = ^{acc_req_i.insn[31:15], acc_req_i.insn[11:0], acc_req_i.frm,
                        acc_req_i.store_pending, acc_req_i.acc_cons_en,
                        acc_req_i.inval_ready};

    always_comb begin
        w_entry          = '0;
        w_entry.trans_id = acc_req_i.trans_id;
        case (w_op)
            3'b000:  w_entry.result = acc_req_i.rs1 + acc_req_i.rs1;
            3'b001:  w_entry.result = acc_req_i.rs1 + acc_req_i.rs2;
            3'b010:  w_entry.result = acc_req_i.rs1 - acc_req_i.rs2;
            3'b011:  w_entry.result = acc_req_i.rs1 ^ acc_req_i.rs2;
            3'b100:  w_entry.result = acc_req_i.rs1 << acc_req_i.rs2[SHW-1:0];
            3'b101:  w_entry.result = acc_req_i.rs1 >> acc_req_i.rs2[SHW-1:0];
            default: w_entry.error  = 1'b1;
        endcase
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if (flush_i) begin
            w_cnt_next = '0;
        end else begin
            case ({w_req_fire, w_resp_fire})
                2'b10:   w_cnt_next = r_cnt + CNT_W'(1);
                2'b01:   w_cnt_next = r_cnt - CNT_W'(1);
                default: w_cnt_next = r_cnt;
            endcase
        end
    end

    generate
        if (LATENCY == 0) begin : g_no_pipe
            assign w_fifo_write = w_req_fire;
            assign w_fifo_wdata = w_entry;
        end else begin : g_pipe
            logic [LATENCY-1:0] r_valid;
            entry_t             r_data [LATENCY];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_valid <= '0;
                end else if (flush_i) begin
                    r_valid <= '0;
                end else begin
                    r_valid[0] <= w_req_fire;
                    for (int i = 1; i < LATENCY; i++) begin
                        r_valid[i] <= r_valid[i-1];
                    end
                end
            end

            // Payload is free-running; only the valid bits carry meaning.
            always_ff @(posedge clk_i) begin
                r_data[0] <= w_entry;
                for (int i = 1; i < LATENCY; i++) begin
                    r_data[i] <= r_data[i-1];
                end
            end

            assign w_fifo_write = r_valid[LATENCY-1];
            assign w_fifo_wdata = r_data[LATENCY-1];
        end
    endgenerate

    // Credits bound pipeline plus FIFO occupancy, so the push never overflows.
    assign w_fifo_push = w_fifo_write && !flush_i;

    always_comb begin
        w_fifo_cnt_next = r_fifo_cnt;
        if (flush_i) begin
            w_fifo_cnt_next = '0;
        end else begin
            case ({w_fifo_push, w_resp_fire})
                2'b10:   w_fifo_cnt_next = r_fifo_cnt + CNT_W'(1);
                2'b01:   w_fifo_cnt_next = r_fifo_cnt - CNT_W'(1);
                default: w_fifo_cnt_next = r_fifo_cnt;
            endcase
        end
    end

    entry_t r_mem [MAX_OUTSTANDING];

    always_ff @(posedge clk_i) begin
        if (w_fifo_push) begin
            r_mem[r_wr_ptr] <= w_fifo_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_cnt   <= '0;
            r_resp_valid <= 1'b0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_req_ready  <= 1'b0;
        end else begin
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_fifo_push) r_wr_ptr <= next_ptr(r_wr_ptr);
                if (w_resp_fire) r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            r_fifo_cnt   <= w_fifo_cnt_next;
            r_resp_valid <= (w_fifo_cnt_next != '0);
            r_cnt        <= w_cnt_next;
            r_busy       <= (w_cnt_next != '0);
            r_req_ready  <= (w_cnt_next < MAX_CNT) && !flush_i;
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    // Head fields are masked while empty so stale FIFO contents never leak out.
    always_comb begin
        acc_resp_o            = '0;
        acc_resp_o.req_ready  = r_req_ready;
        acc_resp_o.resp_valid = r_resp_valid;
        if (r_resp_valid) begin
            acc_resp_o.result   = w_head.result;
            acc_resp_o.trans_id = w_head.trans_id;
            acc_resp_o.error    = w_head.error;
        end
    end

    assign busy_o = r_busy;

endmodule

// File: tb/tb_dummy_accelerator_pipe.sv
// Scoreboard bench: dut0 runs LATENCY=2/MAX_OUTSTANDING=4, dut1 runs
// LATENCY=0/MAX_OUTSTANDING=1 and takes the mid-transaction reset.
module tb_dummy_accelerator_pipe;
    import acc_pkg::*;

    typedef struct {
        logic [63:0] result;
        logic [3:0]  id;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst0_n, rst1_n, flush0, flush1, busy0, busy1;
    accelerator_req_t  req0, req1;
    accelerator_resp_t resp0, resp1;

    dummy_accelerator_pipe #(.LATENCY(2), .MAX_OUTSTANDING(4)) dut0 (
        .clk_i(clk), .rst_ni(rst0_n), .flush_i(flush0),
        .acc_req_i(req0), .acc_resp_o(resp0), .busy_o(busy0));

    dummy_accelerator_pipe #(.LATENCY(0), .MAX_OUTSTANDING(1)) dut1 (
        .clk_i(clk), .rst_ni(rst1_n), .flush_i(flush1),
        .acc_req_i(req1), .acc_resp_o(resp1), .busy_o(busy1));

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];
    bit   done = 0;

    bit          stall [2];
    logic [63:0] h_res [2];
    logic [3:0]  h_id  [2];
    logic        h_err [2];
    bit          pflush[2];
    int          outst [2];
    int          maxo  [2];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon(input int d, input logic rstn, input logic flush,
                       input logic rq_valid, input logic rs_ready,
                       input logic rq_ready, input logic rs_valid,
                       input logic [63:0] res, input logic [3:0] id, input logic err);
        exp_t e;
        bit   have;
        if (!rstn) begin
            stall[d]  = 0;
            pflush[d] = 0;
            outst[d]  = 0;
            return;
        end
        if (stall[d] && !pflush[d]) begin
            chk($sformatf("hold_valid%0d", d), rs_valid, 1'b1);
            chk($sformatf("hold_result%0d", d), res, h_res[d]);
            chk($sformatf("hold_id%0d", d), id, h_id[d]);
            chk($sformatf("hold_err%0d", d), err, h_err[d]);
        end
        if (rs_valid && rs_ready) begin
            have = 0;
            if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1; end
            if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1; end
            if (!have) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp%0d: got id %0d result %0h, expected no response", d, id, res);
            end else begin
                $display("[%0t] dut%0d resp id=%0d result=%h err=%0d", $time, d, id, res, err);
                chk($sformatf("result%0d_id%0d", d, e.id), res, e.result);
                chk($sformatf("trans_id%0d", d), id, e.id);
                chk($sformatf("error%0d_id%0d", d, e.id), err, e.err);
            end
        end
        if (flush) outst[d] = 0;
        else outst[d] = outst[d] + int'(rq_valid && rq_ready) - int'(rs_valid && rs_ready);
        if (outst[d] > maxo[d]) maxo[d] = outst[d];
        stall[d]  = rs_valid && !rs_ready;
        h_res[d]  = res;
        h_id[d]   = id;
        h_err[d]  = err;
        pflush[d] = flush;
    endtask

    task automatic monitor_loop();
        while (!done) begin
            @(negedge clk);
            mon(0, rst0_n, flush0, req0.req_valid, req0.resp_ready, resp0.req_ready,
                resp0.resp_valid, resp0.result, resp0.trans_id, resp0.error);
            mon(1, rst1_n, flush1, req1.req_valid, req1.resp_ready, resp1.req_ready,
                resp1.resp_valid, resp1.result, resp1.trans_id, resp1.error);
        end
    endtask

    task automatic send(input int d, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] b, input logic [3:0] id,
                        input logic [63:0] exp_res, input logic exp_err);
        exp_t        e;
        logic [31:0] ins;
        bit          ok;
        ok        = 0;
        ins       = 32'h0000_007B;
        ins[14:12] = f3;
        e.result  = exp_res;
        e.id      = id;
        e.err     = exp_err;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (d == 0) begin
                req0.req_valid = 1'b1; req0.insn = ins; req0.rs1 = a; req0.rs2 = b; req0.trans_id = id;
                ok = resp0.req_ready && !flush0;
                if (ok) q0.push_back(e);
            end else begin
                req1.req_valid = 1'b1; req1.insn = ins; req1.rs1 = a; req1.rs2 = b; req1.trans_id = id;
                ok = resp1.req_ready && !flush1;
                if (ok) q1.push_back(e);
            end
            tick();
        end
        if (d == 0) req0.req_valid = 1'b0;
        else req1.req_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout%0d: id %0d never accepted, expected acceptance", d, id);
        end
    endtask

    task automatic drain(input int d);
        for (int i = 0; i < 100 && ((d == 0) ? q0.size() : q1.size()) != 0; i++) tick();
        chk($sformatf("drain%0d", d), (d == 0) ? q0.size() : q1.size(), 0);
    endtask

    initial begin
        req0 = '0; req1 = '0; flush0 = 0; flush1 = 0; rst0_n = 0; rst1_n = 0;
        fork
            monitor_loop();
        join_none
        repeat (3) tick();
        chk("reset_resp0", resp0, 0);
        chk("reset_busy0", busy0, 0);
        chk("reset_resp1", resp1, 0);
        rst0_n = 1; rst1_n = 1;
        chk("ready_after_rst_0", resp0.req_ready, 0);
        tick();
        chk("ready_after_rst_1", resp0.req_ready, 1);

        // Single request: latency and busy fall.
        req0.resp_ready = 1;
        send(0, 3'b001, 64'd5, 64'd7, 4'd3, 64'd12, 0);
        chk("lat_t1", resp0.resp_valid, 0);
        tick();
        chk("lat_t2", resp0.resp_valid, 0);
        tick();
        chk("lat_t3", resp0.resp_valid, 1);
        chk("busy_before_pop", busy0, 1);
        tick();
        chk("busy_after_pop", busy0, 0);
        chk("valid_after_pop", resp0.resp_valid, 0);

        // Back-to-back with backpressure: credits run out after 4.
        req0.resp_ready = 0;
        for (int i = 0; i < 4; i++) send(0, 3'b001, 64'(i), 64'd10, 4'(i), 64'(i + 10), 0);
        chk("ready_full", resp0.req_ready, 0);
        fork
            begin
                send(0, 3'b001, 64'd4, 64'd10, 4'd4, 64'd14, 0);
                send(0, 3'b001, 64'd5, 64'd10, 4'd5, 64'd15, 0);
            end
            begin
                repeat (6) tick();
                req0.resp_ready = 1;
            end
        join
        drain(0);

        // Arithmetic edges.
        send(0, 3'b000, 64'h8000_0000_0000_0000, 64'h1234, 4'd1, 64'd0, 0);
        send(0, 3'b010, 64'd0, 64'd1, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        send(0, 3'b100, 64'd1, 64'h41, 4'd3, 64'd2, 0);
        send(0, 3'b111, 64'd5, 64'd6, 4'd4, 64'd0, 1);
        send(0, 3'b011, 64'hF0F0, 64'hFF00, 4'd5, 64'h0FF0, 0);
        send(0, 3'b101, 64'h8000_0000_0000_0000, 64'h3F, 4'd6, 64'd1, 0);
        send(0, 3'b110, 64'd9, 64'd9, 4'd7, 64'd0, 1);
        send(0, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'd8, 64'd1, 0);
        drain(0);

        // resp_ready toggling every cycle across FIFO pointer wrap.
        fork
            for (int i = 0; i < 10; i++) send(0, 3'b001, 64'(i), 64'd100, 4'(i), 64'(i + 100), 0);
            for (int k = 0; k < 60; k++) begin
                req0.resp_ready = ~req0.resp_ready;
                tick();
            end
        join
        req0.resp_ready = 1;
        drain(0);

        // Flush with 3 queued, 1 in the pipeline and a request presented.
        req0.resp_ready = 0;
        send(0, 3'b001, 64'd1, 64'd10, 4'd10, 64'd11, 0);
        send(0, 3'b001, 64'd1, 64'd11, 4'd11, 64'd12, 0);
        send(0, 3'b001, 64'd1, 64'd12, 4'd12, 64'd13, 0);
        tick(); tick();
        send(0, 3'b001, 64'd1, 64'd13, 4'd13, 64'd14, 0);
        req0.req_valid = 1; req0.trans_id = 4'd14;
        flush0 = 1;
        q0.delete();
        tick();
        flush0 = 0; req0.req_valid = 0;
        chk("flush_valid", resp0.resp_valid, 0);
        chk("flush_ready", resp0.req_ready, 0);
        chk("flush_busy", busy0, 0);
        tick();
        chk("flush_ready_back", resp0.req_ready, 1);
        req0.resp_ready = 1;
        repeat (5) tick();
        send(0, 3'b001, 64'd4, 64'd5, 4'd9, 64'd9, 0);
        drain(0);

        // Flush on an idle pipe while req_ready is high: request must be dropped.
        req0.req_valid = 1; req0.trans_id = 4'd7;
        flush0 = 1;
        tick();
        flush0 = 0; req0.req_valid = 0;
        repeat (5) tick();
        chk("flush_idle_busy", busy0, 0);

        // LATENCY=0, MAX_OUTSTANDING=1.
        req1.resp_ready = 1;
        send(1, 3'b001, 64'd2, 64'd3, 4'd1, 64'd5, 0);
        chk("l0_valid_t1", resp1.resp_valid, 1);
        chk("l0_ready_inflight", resp1.req_ready, 0);
        tick();
        chk("l0_valid_t2", resp1.resp_valid, 0);
        chk("l0_ready_t2", resp1.req_ready, 1);
        send(1, 3'b010, 64'd10, 64'd3, 4'd2, 64'd7, 0);
        drain(1);

        // Reset pulsed while a response is stalled at the head.
        req1.resp_ready = 0;
        send(1, 3'b001, 64'd1, 64'd1, 4'd3, 64'd2, 0);
        chk("l0_stalled", resp1.resp_valid, 1);
        #2 rst1_n = 0;
        q1.delete();
        #1;
        chk("rst_mid_resp1", resp1, 0);
        chk("rst_mid_busy1", busy1, 0);
        tick(); tick();
        rst1_n = 1;
        req1.resp_ready = 1;
        chk("rst_mid_ready0", resp1.req_ready, 0);
        tick();
        chk("rst_mid_ready1", resp1.req_ready, 1);
        chk("rst_mid_novalid", resp1.resp_valid, 0);
        repeat (3) tick();
        send(1, 3'b011, 64'hA, 64'h5, 4'd4, 64'hF, 0);
        drain(1);

        chk("max_outstanding0", maxo[0], 4);
        chk("max_outstanding1", maxo[1], 1);
        done = 1;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
